// File: rtl/regfile_mp_if.sv
// Register-file bus: decode-side read/reserve ports and writeback write port.
`timescale 1ns/1ps
interface regfile_mp_if #(
    parameter int unsigned W   = 32,
    parameter int unsigned AW  = 5,
    parameter int unsigned NRD = 2
);
    logic [NRD-1:0]    rd_en;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*W-1:0]  rd_data;
    logic [NRD-1:0]    rd_valid;
    logic [NRD-1:0]    rd_pend;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [W-1:0]      wr_data;
    logic              resv_en;
    logic [AW-1:0]     resv_addr;
    logic              any_pend;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, resv_en, resv_addr,
        input  rd_data, rd_valid, rd_pend, any_pend
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, resv_en, resv_addr,
        output rd_data, rd_valid, rd_pend, any_pend
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass and RAW pending scoreboard.
`timescale 1ns/1ps
module regfile_mp #(
    parameter int unsigned W        = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ZERO_ADDR = '0;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [W-1:0]     r_rf [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_pend_nxt;
    logic [NRD*W-1:0] r_rd_data;
    logic [NRD*W-1:0] w_rd_data;
    logic [NRD-1:0]   r_rd_valid;
    logic [NRD-1:0]   r_rd_pend;
    logic [NRD-1:0]   w_rd_pend;
    logic [AW-1:0]    w_a;
    logic             w_hit;
    logic             w_wr_ok;
    logic             w_resv_ok;

    // Register 0 swallows writes and reservations when hardwired to zero
    assign w_wr_ok   = bus.wr_en   && !(HAS_ZERO && (bus.wr_addr   == ZERO_ADDR));
    assign w_resv_ok = bus.resv_en && !(HAS_ZERO && (bus.resv_addr == ZERO_ADDR));

    // Per-port read value and pending flag: zero reg, then same-edge bypass, then array
    always_comb begin
        w_rd_data = r_rd_data;
        w_rd_pend = r_rd_pend;
        w_a       = '0;
        w_hit     = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            w_a   = bus.rd_addr[i*AW +: AW];
            w_hit = bus.wr_en && (bus.wr_addr == w_a);
            if (bus.rd_en[i]) begin
                if (HAS_ZERO && (w_a == ZERO_ADDR)) begin
                    w_rd_data[i*W +: W] = '0;
                end else if (w_hit) begin
                    w_rd_data[i*W +: W] = bus.wr_data;
                end else begin
                    w_rd_data[i*W +: W] = r_rf[w_a];
                end
                // Bypassed write already clears; same-edge reservation is not visible
                w_rd_pend[i] = w_hit ? 1'b0 : r_pend[w_a];
            end
        end
    end

    // Scoreboard update: writeback clear first, then reservation set wins
    always_comb begin
        w_pend_nxt = r_pend;
        if (bus.wr_en) begin
            w_pend_nxt[bus.wr_addr] = 1'b0;
        end
        if (w_resv_ok) begin
            w_pend_nxt[bus.resv_addr] = 1'b1;
        end
    end

    // Register array write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_rf[k] <= '0;
            end
        end else if (w_wr_ok) begin
            r_rf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Scoreboard and registered read outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= '0;
            r_rd_pend  <= '0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_rd_data  <= w_rd_data;
            r_rd_valid <= bus.rd_en;
            r_rd_pend  <= w_rd_pend;
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_pend  = r_rd_pend;
    assign bus.any_pend = |r_pend;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomized checks of regfile_mp in two configurations.
`timescale 1ns/1ps
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_if #(.W(32), .AW(5), .NRD(2)) b0 ();
    regfile_mp_if #(.W(64), .AW(4), .NRD(4)) b1 ();

    regfile_mp #(.W(32), .DEPTH(32), .NRD(2), .ZERO_REG(1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    regfile_mp #(.W(64), .DEPTH(16), .NRD(4), .ZERO_REG(0)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = dut0, 1 = dut1
    logic [63:0] m_rf   [2][32];
    bit          m_pend [2][32];
    logic [63:0] e_data [2][4];
    bit          e_valid[2][4];
    bit          e_pend [2][4];
    int unsigned m_depth[2] = '{32, 16};
    int unsigned m_nrd  [2] = '{2, 4};
    bit          m_zr   [2] = '{1'b1, 1'b0};

    // Stimulus for the current cycle
    bit          s_rd_en[2][4];
    int unsigned s_addr [2][4];
    bit          s_wr   [2];
    int unsigned s_wa   [2];
    logic [63:0] s_wd   [2];
    bit          s_rv   [2];
    int unsigned s_ra   [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b0.rd_en = '0; b0.rd_addr = '0; b0.wr_en = 1'b0; b0.wr_addr = '0;
        b0.wr_data = '0; b0.resv_en = 1'b0; b0.resv_addr = '0;
        b1.rd_en = '0; b1.rd_addr = '0; b1.wr_en = 1'b0; b1.wr_addr = '0;
        b1.wr_data = '0; b1.resv_en = 1'b0; b1.resv_addr = '0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 32; a++) begin
                m_rf[d][a]   = '0;
                m_pend[d][a] = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                e_data[d][i]  = '0;
                e_valid[d][i] = 1'b0;
                e_pend[d][i]  = 1'b0;
            end
        end
    endtask

    // One clock edge of the architectural behaviour for configuration d
    task automatic model_step(input int d);
        int unsigned a;
        bit hit;
        for (int i = 0; i < 4; i++) begin
            e_valid[d][i] = (i < m_nrd[d]) && s_rd_en[d][i];
            if (e_valid[d][i]) begin
                a   = s_addr[d][i];
                hit = s_wr[d] && (s_wa[d] == a);
                if (m_zr[d] && a == 0) e_data[d][i] = '0;
                else if (hit)          e_data[d][i] = s_wd[d];
                else                   e_data[d][i] = m_rf[d][a];
                e_pend[d][i] = hit ? 1'b0 : m_pend[d][a];
            end
        end
        if (s_wr[d]) begin
            if (!(m_zr[d] && s_wa[d] == 0)) m_rf[d][s_wa[d]] = s_wd[d];
            m_pend[d][s_wa[d]] = 1'b0;
        end
        if (s_rv[d] && !(m_zr[d] && s_ra[d] == 0)) m_pend[d][s_ra[d]] = 1'b1;
    endtask

    function automatic logic exp_any(input int d);
        logic r = 1'b0;
        for (int a = 0; a < 32; a++) r |= m_pend[d][a];
        return r;
    endfunction

    function automatic int unsigned rnd_addr(input int d);
        if ($urandom_range(0, 1) == 0) return $urandom_range(0, 3);
        return $urandom_range(0, m_depth[d] - 1);
    endfunction

    task automatic randomize_stim();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                s_rd_en[d][i] = ($urandom_range(0, 1) == 1);
                s_addr[d][i]  = rnd_addr(d);
            end
            s_wr[d] = ($urandom_range(0, 1) == 1);
            s_wa[d] = rnd_addr(d);
            s_wd[d] = {$urandom, $urandom};
            if (d == 0) s_wd[d][63:32] = '0;
            s_rv[d] = ($urandom_range(0, 2) == 0);
            s_ra[d] = rnd_addr(d);
        end
    endtask

    task automatic drive_stim();
        for (int i = 0; i < 2; i++) begin
            b0.rd_en[i]         = s_rd_en[0][i];
            b0.rd_addr[i*5 +: 5] = 5'(s_addr[0][i]);
        end
        b0.wr_en = s_wr[0]; b0.wr_addr = 5'(s_wa[0]); b0.wr_data = 32'(s_wd[0]);
        b0.resv_en = s_rv[0]; b0.resv_addr = 5'(s_ra[0]);
        for (int i = 0; i < 4; i++) begin
            b1.rd_en[i]         = s_rd_en[1][i];
            b1.rd_addr[i*4 +: 4] = 4'(s_addr[1][i]);
        end
        b1.wr_en = s_wr[1]; b1.wr_addr = 4'(s_wa[1]); b1.wr_data = s_wd[1];
        b1.resv_en = s_rv[1]; b1.resv_addr = 4'(s_ra[1]);
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk("rnd0_data",  64'(b0.rd_data[i*32 +: 32]), e_data[0][i]);
            chk("rnd0_valid", 64'(b0.rd_valid[i]), 64'(e_valid[0][i]));
            chk("rnd0_pend",  64'(b0.rd_pend[i]),  64'(e_pend[0][i]));
        end
        for (int i = 0; i < 4; i++) begin
            chk("rnd1_data",  b1.rd_data[i*64 +: 64], e_data[1][i]);
            chk("rnd1_valid", 64'(b1.rd_valid[i]), 64'(e_valid[1][i]));
            chk("rnd1_pend",  64'(b1.rd_pend[i]),  64'(e_pend[1][i]));
        end
        chk("rnd0_any_pend", 64'(b0.any_pend), 64'(exp_any(0)));
        chk("rnd1_any_pend", 64'(b1.any_pend), 64'(exp_any(1)));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #12;
        // Reset state
        chk("rst0_data",  64'(b0.rd_data), 64'h0);
        chk("rst0_valid", 64'(b0.rd_valid), 64'h0);
        chk("rst0_pend",  64'(b0.rd_pend), 64'h0);
        chk("rst0_any",   64'(b0.any_pend), 64'h0);
        chk("rst1_valid", 64'(b1.rd_valid), 64'h0);
        chk("rst1_any",   64'(b1.any_pend), 64'h0);
        rst = 1'b0;

        // Write then read with latency 1, then hold
        b0.wr_en = 1'b1; b0.wr_addr = 5'd5; b0.wr_data = 32'hDEADBEEF;
        tick(); idle();
        b0.rd_en = 2'b01; b0.rd_addr[4:0] = 5'd5;
        tick(); idle();
        chk("t2_data",  64'(b0.rd_data[31:0]), 64'hDEADBEEF);
        chk("t2_valid", 64'(b0.rd_valid[0]), 64'h1);
        tick();
        chk("t2_idle_valid", 64'(b0.rd_valid[0]), 64'h0);
        chk("t2_hold_data",  64'(b0.rd_data[31:0]), 64'hDEADBEEF);

        // Bypass: reserved R7 written and read on all ports the same edge
        b0.resv_en = 1'b1; b0.resv_addr = 5'd7;
        tick(); idle();
        chk("t3_resv_any", 64'(b0.any_pend), 64'h1);
        b0.wr_en = 1'b1; b0.wr_addr = 5'd7; b0.wr_data = 32'h1234;
        b0.rd_en = 2'b11; b0.rd_addr = {5'd7, 5'd7};
        tick(); idle();
        chk("t3_p0", 64'(b0.rd_data[31:0]),  64'h1234);
        chk("t3_p1", 64'(b0.rd_data[63:32]), 64'h1234);
        chk("t3_pend", 64'(b0.rd_pend), 64'h0);
        chk("t3_any",  64'(b0.any_pend), 64'h0);

        // Zero register: hardwired on dut0, ordinary on dut1
        b0.wr_en = 1'b1; b0.wr_addr = 5'd0; b0.wr_data = 32'hFFFFFFFF;
        b0.resv_en = 1'b1; b0.resv_addr = 5'd0;
        b1.wr_en = 1'b1; b1.wr_addr = 4'd0; b1.wr_data = 64'hFFFFFFFF_FFFFFFFF;
        b1.resv_en = 1'b1; b1.resv_addr = 4'd0;
        tick(); idle();
        chk("t4_any0", 64'(b0.any_pend), 64'h0);
        chk("t4_any1", 64'(b1.any_pend), 64'h1);
        b0.rd_en = 2'b11; b0.rd_addr = '0;
        b0.wr_en = 1'b1; b0.wr_addr = 5'd0; b0.wr_data = 32'hA5A5A5A5;
        b1.rd_en = 4'hF; b1.rd_addr = '0;
        tick(); idle();
        chk("t4_r0_zero", 64'(b0.rd_data), 64'h0);
        chk("t4_r0_pend0", 64'(b0.rd_pend), 64'h0);
        for (int i = 0; i < 4; i++) chk("t4_r0_ones", b1.rd_data[i*64 +: 64], 64'hFFFFFFFF_FFFFFFFF);
        chk("t4_r0_pend1", 64'(b1.rd_pend), 64'hF);

        // Scoreboard
        b0.resv_en = 1'b1; b0.resv_addr = 5'd3;
        tick(); idle();
        chk("t5_any_set", 64'(b0.any_pend), 64'h1);
        b0.rd_en = 2'b10; b0.rd_addr[9:5] = 5'd3;
        tick(); idle();
        chk("t5_rd_pend", 64'(b0.rd_pend[1]), 64'h1);
        b0.wr_en = 1'b1; b0.wr_addr = 5'd3; b0.wr_data = 32'h33;
        b0.resv_en = 1'b1; b0.resv_addr = 5'd3;
        tick(); idle();
        chk("t5_set_wins", 64'(b0.any_pend), 64'h1);
        b0.rd_en = 2'b01; b0.rd_addr[4:0] = 5'd3;
        tick(); idle();
        chk("t5_still_pend", 64'(b0.rd_pend[0]), 64'h1);
        b0.wr_en = 1'b1; b0.wr_addr = 5'd3; b0.wr_data = 32'h44;
        tick(); idle();
        chk("t5_cleared", 64'(b0.any_pend), 64'h0);
        b0.rd_en = 2'b01; b0.rd_addr[4:0] = 5'd9;
        b0.resv_en = 1'b1; b0.resv_addr = 5'd9;
        tick(); idle();
        chk("t5_resv_same_edge", 64'(b0.rd_pend[0]), 64'h0);
        chk("t5_resv_any", 64'(b0.any_pend), 64'h1);

        // Asynchronous reset mid-stream with pending bits set
        b0.rd_en = 2'b01; b0.rd_addr[4:0] = 5'd5;
        b0.resv_en = 1'b1; b0.resv_addr = 5'd2;
        b1.resv_en = 1'b1; b1.resv_addr = 4'd4;
        tick(); idle();
        chk("t1_pre_valid", 64'(b0.rd_valid[0]), 64'h1);
        chk("t1_pre_any1",  64'(b1.any_pend), 64'h1);
        #3 rst = 1'b1;
        #1;
        chk("t1_data0",  64'(b0.rd_data), 64'h0);
        chk("t1_valid0", 64'(b0.rd_valid), 64'h0);
        chk("t1_any0",   64'(b0.any_pend), 64'h0);
        chk("t1_data1",  b1.rd_data[63:0], 64'h0);
        chk("t1_any1",   64'(b1.any_pend), 64'h0);
        rst = 1'b0;
        tick();
        for (int a = 0; a < 16; a++) begin
            b0.rd_en = 2'b11; b0.rd_addr = {5'(a + 16), 5'(a)};
            b1.rd_en = 4'hF;  b1.rd_addr = {4{4'(a)}};
            tick(); idle();
            chk("t1_clear0", 64'(b0.rd_data), 64'h0);
            chk("t1_clear1", b1.rd_data[63:0], 64'h0);
        end

        // Randomized traffic against the reference model, with occasional resets
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            randomize_stim();
            drive_stim();
            model_step(0);
            model_step(1);
            tick();
            compare_all();
            if (cyc % 2500 == 2499) begin
                rst = 1'b1;
                #1;
                model_reset();
                compare_all();
                rst = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
